bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits between the five-bit adder and the seven-segment decoders. The adder's binary sum goes in; packed BCD digits come out, one nibble per HEX digit.
- This lets HEX1/HEX0 show decimal sums (0-62) instead of hex.
- Start/ready/done handshake so the operand-capture logic can request a new conversion.

Parameters:
- WIDTH, 8, width of the binary input in bits (must be >= 1).
- DIGITS, 3, number of BCD output digits (must be >= 1).

Ports:
- CLOCK_50  input  1  system clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only when ready=1.
- bin  input  WIDTH  unsigned binary value; captured on the accepting edge.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse; bcd/overflow are updated on the same edge.
- bcd  output  4*DIGITS  packed result; ones digit in bcd[3:0], tens in bcd[7:4], and so on.
- overflow  output  1  high when the value needs more than DIGITS digits; registered with done.

Behaviour:
- Reset (asynchronous, any time including mid-conversion):
  - state=IDLE, ready=1, done=0, bcd=0, overflow=0.
  - Internal shift register and counter are cleared.
  - Any conversion in progress is discarded; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1, done=0.
  - If start=1 at an edge: load bin into the binary shift register, clear the BCD scratch register and bit counter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - ready=0.
  - Each edge, in order:
    - add 3 to every scratch digit >= 5;
    - shift {scratch, binary} left by 1;
    - OR the bit shifted out of the top digit into a sticky overflow flag;
    - increment the counter.
  - Exactly WIDTH edges are spent in SHIFT.
  - On the WIDTH-th edge: load bcd with the final scratch value and overflow with the sticky flag, set done=1, go to DONE.
- DONE:
  - ready=0, done=1 for exactly this one cycle.
  - The next edge clears done, sets ready=1 and returns to IDLE.
  - start is ignored during DONE.
- Latency:
  - start accepted at edge 0 -> bcd/overflow valid and done=1 after edge WIDTH.
  - ready returns after edge WIDTH+1.
  - Throughput is one conversion per WIDTH+2 cycles.
- Hold behaviour:
  - bcd and overflow hold their last result between conversions; they change only on the done edge or on reset.
  - Intermediate scratch values are never visible on bcd.
  - bin is sampled only at acceptance; changes during SHIFT have no effect.
- start while ready=0: ignored and not queued. A start held high continuously gives back-to-back conversions, each accepted on the edge where ready=1.
- Arithmetic:
  - All arithmetic is unsigned.
  - Each scratch digit stays 0-9 after every step.
  - Bits shifted out of the top digit are discarded except for the sticky overflow flag.
- Overflow result:
  - If overflow=1, bcd holds the low DIGITS digits of the true decimal value, i.e. value mod 10^DIGITS.
  - Example: 255 with DIGITS=2 gives bcd=0x55.
- WIDTH=1 edge case: SHIFT lasts a single cycle; the latency rule above still applies.

Test Plan:
- Reset, then start with bin=0 (defaults) -> ready drops the next cycle; done pulses exactly once after 8 shift cycles; bcd=0x000, overflow=0; ready=1 one cycle later.
- bin=62 (max adder sum 31+31) -> bcd=0x062, overflow=0. Then bin=9 -> bcd=0x009. bcd holds 0x062 until the second done edge.
- bin=255 -> bcd=0x255. Also sweep bin 0..255 against a decimal reference model: every result matches, every done is a single cycle, and each done arrives exactly WIDTH edges after acceptance.
- Start accepted with bin=100; pulse start again and change bin to 7 during SHIFT -> only one done; bcd=0x100. Holding start high for 3 conversions of 42 -> done pulses spaced exactly 10 cycles apart.
- Assert RESET asynchronously (not edge-aligned) 4 cycles into converting 200 -> bcd=0, done=0, ready=1 immediately; no later done pulse. A fresh start then converts normally.
- DIGITS=2, WIDTH=8: bin=99 -> bcd=0x99, overflow=0. bin=255 -> bcd=0x55, overflow=1. Following bin=12 -> bcd=0x12, overflow=0 (flag cleared per conversion).

Source files
------------

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and data bundle between the operand-capture logic and the BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  ready;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (output start, output bin, input ready, input done, input bcd, input overflow);
    modport slave  (input start, input bin, output ready, output done, output bcd, output overflow);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with start/ready/done handshake and a sticky overflow flag.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] bin_reg;
    logic [BW-1:0]    scratch_reg;
    logic [CW-1:0]    count_reg;
    logic             sticky_reg;
    logic [BW-1:0]    bcd_reg;
    logic             overflow_reg;

    logic [BW-1:0]    adj;
    logic [BW-1:0]    scratch_next;
    logic [WIDTH-1:0] bin_next;
    logic             sticky_next;
    logic             last;

    // Add-3 correction on every digit that would exceed 9 after doubling.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                                    scratch_reg[4*gi +: 4] + 4'd3 :
                                    scratch_reg[4*gi +: 4];
        end
    endgenerate

    assign scratch_next = {adj[BW-2:0], bin_reg[WIDTH-1]};
    assign bin_next     = bin_reg << 1;
    assign sticky_next  = sticky_reg | adj[BW-1];
    assign last         = (count_reg == CW'(WIDTH - 1));

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_reg    <= IDLE;
            bin_reg      <= '0;
            scratch_reg  <= '0;
            count_reg    <= '0;
            sticky_reg   <= 1'b0;
            bcd_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        bin_reg     <= bus.bin;
                        scratch_reg <= '0;
                        count_reg   <= '0;
                        sticky_reg  <= 1'b0;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_reg     <= bin_next;
                    scratch_reg <= scratch_next;
                    sticky_reg  <= sticky_next;
                    count_reg   <= count_reg + 1'b1;
                    if (last) begin
                        bcd_reg      <= scratch_next;
                        overflow_reg <= sticky_next;
                        state_reg    <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ready    = (state_reg == IDLE);
    assign bus.done     = (state_reg == DONE);
    assign bus.bcd      = bcd_reg;
    assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance share one clock.
module tb_bin_to_bcd_seq;
    logic clk;
    logic rst;

    bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) ifa ();
    bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(2)) ifb ();

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (.CLOCK_50(clk), .RESET(rst), .bus(ifa.slave));
    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (.CLOCK_50(clk), .RESET(rst), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          sel;
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? ifa.ready : ifb.ready;
    endfunction

    function automatic logic dn(input int sel);
        return (sel == 0) ? ifa.done : ifb.done;
    endfunction

    function automatic logic [11:0] dec_bcd(input int v, input int digits);
        logic [11:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r = r | (12'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    // Request one conversion, measure edges from acceptance to done, check the pulse shape.
    task automatic convert(input int sel, input logic [7:0] v,
                           output logic [11:0] rb, output logic ro, output int lat);
        int n;
        n = 0;
        while (!rdy(sel) && n < 40) begin @(negedge clk); n++; end
        if (sel == 0) begin ifa.start = 1'b1; ifa.bin = v; end
        else          begin ifb.start = 1'b1; ifb.bin = v; end
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        check("ready_drop", 32'(rdy(sel)), 32'd0);
        n = 0;
        while (!dn(sel) && n < 40) begin @(negedge clk); n++; end
        lat = n;
        rb  = (sel == 0) ? ifa.bcd : {4'h0, ifb.bcd};
        ro  = (sel == 0) ? ifa.overflow : ifb.overflow;
        @(negedge clk);
        check("done_single", 32'(dn(sel)), 32'd0);
        check("ready_back", 32'(rdy(sel)), 32'd1);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        logic [11:0] rb;
        logic        ro;
        int          lat;
        int          t[3];
        int          k;
        int          n;

        vecs[0]  = '{0, 8'd0,   12'h000, 1'b0};
        vecs[1]  = '{0, 8'd62,  12'h062, 1'b0};
        vecs[2]  = '{0, 8'd9,   12'h009, 1'b0};
        vecs[3]  = '{0, 8'd255, 12'h255, 1'b0};
        vecs[4]  = '{0, 8'd1,   12'h001, 1'b0};
        vecs[5]  = '{0, 8'd10,  12'h010, 1'b0};
        vecs[6]  = '{0, 8'd128, 12'h128, 1'b0};
        vecs[7]  = '{0, 8'd199, 12'h199, 1'b0};
        vecs[8]  = '{1, 8'd99,  12'h099, 1'b0};
        vecs[9]  = '{1, 8'd255, 12'h055, 1'b1};
        vecs[10] = '{1, 8'd12,  12'h012, 1'b0};
        vecs[11] = '{1, 8'd100, 12'h000, 1'b1};

        ifa.start = 1'b0; ifa.bin = '0;
        ifb.start = 1'b0; ifb.bin = '0;
        rst = 1'b1;
        #12;
        check("rst_ready", 32'(ifa.ready), 32'd1);
        check("rst_done", 32'(ifa.done), 32'd0);
        check("rst_bcd", 32'(ifa.bcd), 32'd0);
        check("rst_ovf", 32'(ifa.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].sel, vecs[i].bin, rb, ro, lat);
            $display("vec %0d dut%0d bin=%0d bcd=0x%03h ovf=%0b lat=%0d",
                     i, vecs[i].sel, vecs[i].bin, rb, ro, lat);
            check("vec_latency", 32'(lat), 32'd8);
            check("vec_bcd", 32'(rb), 32'(vecs[i].bcd));
            check("vec_ovf", 32'(ro), 32'(vecs[i].ovf));
        end

        // Result of 62 must hold through the next conversion until its done edge.
        convert(0, 8'd62, rb, ro, lat);
        ifa.start = 1'b1; ifa.bin = 8'd9;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (4) @(negedge clk);
        check("hold_bcd", 32'(ifa.bcd), 32'h062);
        n = 0;
        while (!ifa.done && n < 40) begin @(negedge clk); n++; end
        check("hold_new_bcd", 32'(ifa.bcd), 32'h009);
        $display("hold: bcd=0x%03h after second done", ifa.bcd);
        @(negedge clk);

        // start and bin changes during SHIFT are ignored.
        ifa.start = 1'b1; ifa.bin = 8'd100;
        @(negedge clk);
        ifa.start = 1'b0;
        @(negedge clk);
        ifa.start = 1'b1; ifa.bin = 8'd7;
        @(negedge clk);
        ifa.start = 1'b0;
        k = 0;
        for (int i = 0; i < 25; i++) begin
            if (ifa.done) begin
                k++;
                check("ignore_bcd", 32'(ifa.bcd), 32'h100);
            end
            @(negedge clk);
        end
        check("ignore_done_count", 32'(k), 32'd1);
        $display("ignore: done pulses=%0d bcd=0x%03h", k, ifa.bcd);

        // Continuous start gives back-to-back conversions every WIDTH+2 cycles.
        ifa.start = 1'b1; ifa.bin = 8'd42;
        k = 0; n = 0;
        while (k < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (ifa.done) begin
                t[k] = cyc;
                k++;
                check("b2b_bcd", 32'(ifa.bcd), 32'h042);
            end
        end
        ifa.start = 1'b0;
        check("b2b_count", 32'(k), 32'd3);
        if (k == 3) begin
            check("b2b_spacing1", 32'(t[1] - t[0]), 32'd10);
            check("b2b_spacing2", 32'(t[2] - t[1]), 32'd10);
            $display("b2b: done at cycles %0d %0d %0d", t[0], t[1], t[2]);
        end
        n = 0;
        while (!ifa.ready && n < 40) begin @(negedge clk); n++; end

        // Asynchronous reset mid-conversion discards the result.
        ifa.start = 1'b1; ifa.bin = 8'd200;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_bcd", 32'(ifa.bcd), 32'd0);
        check("arst_done", 32'(ifa.done), 32'd0);
        check("arst_ready", 32'(ifa.ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ifa.done) k++;
        end
        check("arst_no_done", 32'(k), 32'd0);
        convert(0, 8'd200, rb, ro, lat);
        check("arst_fresh_bcd", 32'(rb), 32'h200);
        check("arst_fresh_lat", 32'(lat), 32'd8);
        $display("reset: fresh conversion bcd=0x%03h lat=%0d", rb, lat);

        // Full sweep against a decimal reference, both digit counts.
        for (int v = 0; v < 256; v++) begin
            convert(0, 8'(v), rb, ro, lat);
            check("sweep3_bcd", 32'(rb), 32'(dec_bcd(v, 3)));
            check("sweep3_ovf", 32'(ro), 32'd0);
            check("sweep3_lat", 32'(lat), 32'd8);
        end
        for (int v = 0; v < 256; v += 5) begin
            convert(1, 8'(v), rb, ro, lat);
            check("sweep2_bcd", 32'(rb), 32'(dec_bcd(v, 2)));
            check("sweep2_ovf", 32'(ro), 32'(v >= 100));
        end
        $display("sweep: done");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
